// File: rtl/nibble_mem_pkg.sv
// Shared definitions for the nibble-memory writer and result reader:
// FSM state type, memory geometry and nibble extraction.
package nibble_mem_pkg;

    localparam int unsigned NIB_W     = 4;
    localparam int unsigned ADDR_W    = 4;
    localparam int unsigned MEM_DEPTH = 16;

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StDone
    } state_e;

    // Words up to 64 bits are supported; callers zero-extend narrower words.
    function automatic logic [NIB_W-1:0] get_nibble(input logic [63:0] word,
                                                    input int unsigned idx);
        return word[idx*NIB_W +: NIB_W];
    endfunction

endpackage

// File: rtl/nibble_mem_writer.sv
// Writes a DATA_W-bit word into a 16x4 memory as consecutive nibbles, LS nibble first.
// Optional NIBBLE_WRITER_CHECKSUM_EN appends one XOR-of-nibbles write after the data.
module nibble_mem_writer #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NIB_W  = nibble_mem_pkg::NIB_W,
    parameter int unsigned ADDR_W = nibble_mem_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_address,
    input  logic [DATA_W-1:0] din,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [NIB_W-1:0]  wdata,
    output logic              busy,
    output logic              finish
);
    import nibble_mem_pkg::*;

    localparam int unsigned N = DATA_W / NIB_W;
`ifdef NIBBLE_WRITER_CHECKSUM_EN
    localparam int unsigned N_WR = N + 1;
`else
    localparam int unsigned N_WR = N;
`endif
    localparam int unsigned IDX_W = $clog2(N_WR + 1);

    state_e            state_q;
    logic [DATA_W-1:0] data_q;
    logic [ADDR_W-1:0] addr_q;
    logic [IDX_W-1:0]  idx_q;

`ifdef NIBBLE_WRITER_CHECKSUM_EN
    function automatic logic [NIB_W-1:0] xor_nibbles(input logic [DATA_W-1:0] w);
        logic [NIB_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < int'(N); i++) begin
            acc ^= w[i*NIB_W +: NIB_W];
        end
        return acc;
    endfunction
`endif

    // idx_q holds the index of the next write; nibble 0 is issued on acceptance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            data_q  <= '0;
            addr_q  <= '0;
            idx_q   <= '0;
            we      <= 1'b0;
            waddr   <= '0;
            wdata   <= '0;
            busy    <= 1'b0;
            finish  <= 1'b0;
        end else begin
            finish <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    we <= 1'b0;
                    if (start) begin
                        data_q  <= din;
                        addr_q  <= start_address;
                        idx_q   <= IDX_W'(1);
                        we      <= 1'b1;
                        waddr   <= start_address;
                        wdata   <= get_nibble(64'(din), 0);
                        busy    <= 1'b1;
                        state_q <= StWrite;
                    end
                end
                StWrite: begin
                    if (idx_q == IDX_W'(N_WR)) begin
                        we      <= 1'b0;
                        finish  <= 1'b1;
                        state_q <= StDone;
`ifdef NIBBLE_WRITER_CHECKSUM_EN
                    end else if (idx_q == IDX_W'(N)) begin
                        we    <= 1'b1;
                        waddr <= addr_q + ADDR_W'(N);
                        wdata <= xor_nibbles(data_q);
                        idx_q <= idx_q + 1'b1;
`endif
                    end else begin
                        we    <= 1'b1;
                        waddr <= addr_q + ADDR_W'(idx_q);
                        wdata <= get_nibble(64'(data_q), 32'(idx_q));
                        idx_q <= idx_q + 1'b1;
                    end
                end
                StDone: begin
                    we      <= 1'b0;
                    busy    <= 1'b0;
                    idx_q   <= '0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_mem_writer.sv
// Directed self-checking bench for nibble_mem_writer with a 16x4 behavioural memory
// and a word-reassembling reader model.
module tb_nibble_mem_writer;
    import nibble_mem_pkg::*;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned N      = 4;
`ifdef NIBBLE_WRITER_CHECKSUM_EN
    localparam int unsigned N_WR = N + 1;
`else
    localparam int unsigned N_WR = N;
`endif

    logic              clk;
    logic              rst;
    logic              start;
    logic [3:0]        start_address;
    logic [DATA_W-1:0] din;
    logic              we;
    logic [3:0]        waddr;
    logic [3:0]        wdata;
    logic              busy;
    logic              finish;

    nibble_mem_writer #(.DATA_W(DATA_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .start_address(start_address),
        .din          (din),
        .we           (we),
        .waddr        (waddr),
        .wdata        (wdata),
        .busy         (busy),
        .finish       (finish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] mem [16];
    always @(posedge clk) if (we) mem[waddr] <= wdata;

    int cyc = 0;
    int fin_cnt = 0;
    int last_fin = 0;
    int prev_fin = 0;
    int wr_cnt [16];
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (finish === 1'b1) begin
            fin_cnt  <= fin_cnt + 1;
            prev_fin <= last_fin;
            last_fin <= cyc;
        end
        if (we === 1'b1) wr_cnt[waddr] <= wr_cnt[waddr] + 1;
    end

    int passed = 0;
    int total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [15:0] read_word(input logic [3:0] addr);
        logic [15:0] w;
        logic [3:0]  a;
        for (int i = 0; i < 4; i++) begin
            a = addr + 4'(i);
            w[i*4 +: 4] = mem[a];
        end
        return w;
    endfunction

    // Full request with cycle-exact checks of every write, finish and return to idle.
    task automatic do_write(input logic [15:0] dv, input logic [3:0] av);
        logic [3:0] x;
        logic [3:0] a;
        x = dv[3:0] ^ dv[7:4] ^ dv[11:8] ^ dv[15:12];
        @(negedge clk);
        start = 1'b1;
        din = dv;
        start_address = av;
        @(posedge clk);
        #1;
        start = 1'b0;
        din = ~dv;
        start_address = av + 4'd7;
        for (int j = 0; j < int'(N_WR); j++) begin
            @(negedge clk);
            a = av + 4'(j);
            check($sformatf("we[%0h:%0d]", dv, j), 32'(we), 32'd1);
            check($sformatf("waddr[%0h:%0d]", dv, j), 32'(waddr), 32'(a));
            if (j < int'(N)) begin
                check($sformatf("wdata[%0h:%0d]", dv, j), 32'(wdata), 32'(dv[j*4 +: 4]));
            end else begin
                check($sformatf("csum[%0h]", dv), 32'(wdata), 32'(x));
            end
            check($sformatf("busy[%0h:%0d]", dv, j), 32'(busy), 32'd1);
            check($sformatf("nofin[%0h:%0d]", dv, j), 32'(finish), 32'd0);
        end
        @(negedge clk);
        check($sformatf("finish[%0h]", dv), 32'(finish), 32'd1);
        check($sformatf("we_done[%0h]", dv), 32'(we), 32'd0);
        check($sformatf("busy_done[%0h]", dv), 32'(busy), 32'd1);
        @(negedge clk);
        check($sformatf("finish_off[%0h]", dv), 32'(finish), 32'd0);
        check($sformatf("busy_off[%0h]", dv), 32'(busy), 32'd0);
        check($sformatf("we_idle[%0h]", dv), 32'(we), 32'd0);
    endtask

    int f0;
    int w0 [16];
    int wsum;
    logic [3:0] m6;
    logic [3:0] m7;

    initial begin
        for (int i = 0; i < 16; i++) wr_cnt[i] = 0;
        rst = 1'b0;
        start = 1'b0;
        din = '0;
        start_address = '0;
        #12;
        check("rst_we", 32'(we), 32'd0);
        check("rst_waddr", 32'(waddr), 32'd0);
        check("rst_wdata", 32'(wdata), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_finish", 32'(finish), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Basic word at address 0
        f0 = fin_cnt;
        do_write(16'hBEEF, 4'h0);
        check("mem0", 32'(mem[0]), 32'hF);
        check("mem1", 32'(mem[1]), 32'hE);
        check("mem2", 32'(mem[2]), 32'hE);
        check("mem3", 32'(mem[3]), 32'hB);
        check("read_beef", 32'(read_word(4'h0)), 32'hBEEF);
        check("fin_once_beef", 32'(fin_cnt - f0), 32'd1);

        // Address wrap
        w0 = wr_cnt;
        do_write(16'h1234, 4'hE);
        check("memE", 32'(mem[14]), 32'h4);
        check("memF", 32'(mem[15]), 32'h3);
        check("mem0w", 32'(mem[0]), 32'h2);
        check("mem1w", 32'(mem[1]), 32'h1);
        check("read_wrap", 32'(read_word(4'hE)), 32'h1234);
        wsum = 0;
        for (int a = 2; a < 14; a++) wsum += wr_cnt[a] - w0[a];
`ifdef NIBBLE_WRITER_CHECKSUM_EN
        check("wrap_untouched", 32'(wsum), 32'd1);
        check("wrap_csum", 32'(mem[2]), 32'h4);
`else
        check("wrap_untouched", 32'(wsum), 32'd0);
`endif

        // Start re-pulsed during WRITE is ignored
        w0 = wr_cnt;
        f0 = fin_cnt;
        @(negedge clk);
        start = 1'b1;
        din = 16'h5A3C;
        start_address = 4'h8;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        din = 16'hFFFF;
        start_address = 4'h8;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        check("ign_read", 32'(read_word(4'h8)), 32'h5A3C);
        check("ign_fin", 32'(fin_cnt - f0), 32'd1);
        wsum = 0;
        for (int a = 0; a < 16; a++) wsum += wr_cnt[a] - w0[a];
        check("ign_writes", 32'(wsum), 32'(N_WR));

        // Reset after the second write abandons the transfer
        w0 = wr_cnt;
        f0 = fin_cnt;
        m6 = mem[6];
        m7 = mem[7];
        @(negedge clk);
        start = 1'b1;
        din = 16'hA5C3;
        start_address = 4'h4;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("arst_we", 32'(we), 32'd0);
        check("arst_waddr", 32'(waddr), 32'd0);
        check("arst_wdata", 32'(wdata), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (8) @(negedge clk);
        check("arst_mem4", 32'(mem[4]), 32'h3);
        check("arst_mem5", 32'(mem[5]), 32'hC);
        check("arst_mem6", 32'(mem[6] === m6), 32'd1);
        check("arst_mem7", 32'(mem[7] === m7), 32'd1);
        check("arst_wr6", 32'(wr_cnt[6] - w0[6]), 32'd0);
        check("arst_wr7", 32'(wr_cnt[7] - w0[7]), 32'd0);
        check("arst_nofin", 32'(fin_cnt - f0), 32'd0);

        // Held start: re-accepted on return to IDLE, back-to-back spacing
        f0 = fin_cnt;
        @(negedge clk);
        start = 1'b1;
        din = 16'h0F0F;
        start_address = 4'h2;
        @(posedge clk);
        #1;
        din = 16'h7777;
        start_address = 4'h6;
        repeat (N_WR + 3) @(posedge clk);
        #1 start = 1'b0;
        repeat (12) @(negedge clk);
        check("b2b_fin", 32'(fin_cnt - f0), 32'd2);
        check("b2b_spacing", 32'(last_fin - prev_fin), 32'(N_WR + 2));
        check("b2b_read1", 32'(read_word(4'h2)), 32'h0F0F);
        check("b2b_read2", 32'(read_word(4'h6)), 32'h7777);

`ifdef NIBBLE_WRITER_CHECKSUM_EN
        do_write(16'h1234, 4'h0);
        check("csum_mem4", 32'(mem[4]), 32'h4);
        check("csum_read", 32'(read_word(4'h0)), 32'h1234);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
